// File: rtl/prio_arbiter_rr_pkg.sv
// rtl/prio_arbiter_rr_pkg.sv - shared constants and types for the request arbiter
package prio_arbiter_rr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [2:0] GC_NONE = 3'b000;
  localparam logic [2:0] GC_R1   = 3'b001;
  localparam logic [2:0] GC_R2   = 3'b010;
  localparam logic [2:0] GC_R3   = 3'b011;
  localparam logic [2:0] GC_R4   = 3'b100;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic [4:1] gcode_to_onehot(input logic [2:0] code);
    logic [4:1] oh;
    oh = 4'b0000;
    case (code)
      GC_R1:   oh = 4'b0001;
      GC_R2:   oh = 4'b0010;
      GC_R3:   oh = 4'b0100;
      GC_R4:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// rtl/prio_arbiter_rr_if.sv - request/grant bundle between requesters and the arbiter
interface prio_arbiter_rr_if;
  logic [4:1] r;
  logic       mode;
  logic [4:1] g;
  logic [2:0] gcode;
  logic       busy;

  modport master (output r, output mode, input g, input gcode, input busy);
  modport slave  (input r, input mode, output g, output gcode, output busy);
endinterface

// File: rtl/rr_prio_encoder.sv
// rtl/rr_prio_encoder.sv - combinational 4-way priority pick, fixed or rotating after last
import prio_arbiter_rr_pkg::*;

module rr_prio_encoder (
  input  logic [4:1] r,
  input  logic [2:0] last,
  input  logic       mode,
  output logic [4:1] winner,
  output logic [2:0] gcode
);

  logic [3:0] rz;
  logic [1:0] base;
  logic [1:0] cand;
  logic       found;

  assign rz = r;

  // Search steps 1..4 below the last winner (zero-based, mod 4); step 4 lands on last itself.
  always_comb begin
    winner = 4'b0000;
    gcode  = GC_NONE;
    found  = 1'b0;
    cand   = 2'd0;
    base   = (mode == MODE_RR) ? (last[1:0] - 2'd1) : 2'd0;
    for (int s = 1; s <= 4; s++) begin
      cand = base - 2'(s);
      if (!found && rz[cand]) begin
        found  = 1'b1;
        gcode  = {1'b0, cand} + 3'd1;
        winner = gcode_to_onehot(gcode);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// rtl/prio_arbiter_rr.sv - registered grant arbiter with hold limit and one idle cycle per release
import prio_arbiter_rr_pkg::*;

module prio_arbiter_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  prio_arbiter_rr_if.slave     bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t        state, state_next;
  logic [4:1]    g_q, g_next;
  logic [2:0]    gcode_q, gcode_next;
  logic [2:0]    last, last_next;
  logic [HW-1:0] hcnt, hcnt_next;
  logic [4:1]    win;
  logic [2:0]    win_code;

  rr_prio_encoder u_enc (
    .r      (bus.r),
    .last   (last),
    .mode   (bus.mode),
    .winner (win),
    .gcode  (win_code)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      g_q     <= 4'b0000;
      gcode_q <= GC_NONE;
      last    <= GC_R1;
      hcnt    <= '0;
    end else begin
      state   <= state_next;
      g_q     <= g_next;
      gcode_q <= gcode_next;
      last    <= last_next;
      hcnt    <= hcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    g_next     = g_q;
    gcode_next = gcode_q;
    last_next  = last;
    hcnt_next  = hcnt;
    case (state)
      ST_IDLE: begin
        if (|bus.r) begin
          state_next = ST_GRANT;
          g_next     = win;
          gcode_next = win_code;
          last_next  = win_code;
          hcnt_next  = HW'(1);
        end
      end
      ST_GRANT: begin
        // Only the granted line matters here; other requests wait for the idle cycle.
        if (|(bus.r & g_q) && (hcnt < HW'(MAX_HOLD))) begin
          hcnt_next = hcnt + HW'(1);
        end else begin
          state_next = ST_IDLE;
          g_next     = 4'b0000;
          gcode_next = GC_NONE;
          hcnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        g_next     = 4'b0000;
        gcode_next = GC_NONE;
      end
    endcase
  end

  assign bus.g     = g_q;
  assign bus.gcode = gcode_q;
  assign bus.busy  = (state == ST_GRANT);

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb/tb_prio_arbiter_rr.sv - randomized and directed checks of prio_arbiter_rr against a reference model
module tb_prio_arbiter_rr;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  int   m_busy;
  int   m_owner;
  int   m_hold;
  int   m_last;

  prio_arbiter_rr_if bus ();

  prio_arbiter_rr #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pick by walking the rotation order: fixed mode always starts below index 1 (4,3,2,1).
  function automatic int pick(input logic [4:1] rv, input logic md, input int lst);
    int start;
    int idx;
    start = md ? lst : 1;
    for (int s = 1; s <= 4; s++) begin
      idx = ((start - 1 - s) % 4 + 4) % 4 + 1;
      if (rv[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_step(input logic rn, input logic [4:1] rv, input logic md);
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_hold = 0;
    end else if (m_busy == 0) begin
      if (rv != 4'b0000) begin
        m_owner = pick(rv, md, m_last);
        m_last  = m_owner;
        m_busy  = 1;
        m_hold  = 1;
      end
    end else if (rv[m_owner] && m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      m_busy = 0; m_owner = 0;
    end
  endtask

  task automatic cycle(input logic rn, input logic [4:1] rv, input logic md);
    logic [4:1] exp_g;
    @(negedge clk);
    reset_n  = rn;
    bus.r    = rv;
    bus.mode = md;
    @(posedge clk);
    model_step(rn, rv, md);
    #1;
    exp_g = (m_owner == 0) ? 4'b0000 : 4'(1 << (m_owner - 1));
    chk("g", 32'(bus.g), 32'(exp_g));
    chk("gcode", 32'(bus.gcode), 32'(m_owner));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    if (m_busy != 0) chk("hcnt", 32'(dut.hcnt), 32'(m_hold));
  endtask

  initial begin
    logic [4:1] rv;
    logic       md;
    logic       rn;
    checks = 0; errors = 0;
    m_busy = 0; m_owner = 0; m_hold = 0; m_last = 1;
    reset_n = 1'b0; bus.r = 4'b0000; bus.mode = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 1'b0);
    chk("rst_g", 32'(bus.g), 32'h0);
    chk("rst_gcode", 32'(bus.gcode), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    cycle(1'b1, 4'b1111, 1'b0);
    chk("first_grant", 32'(bus.g), 32'h8);
    chk("first_gcode", 32'(bus.gcode), 32'h4);
    cycle(1'b1, 4'b0000, 1'b0);

    cycle(1'b1, 4'b0110, 1'b0);
    chk("fixed_g", 32'(bus.g), 32'h4);
    chk("fixed_gcode", 32'(bus.gcode), 32'h3);
    cycle(1'b1, 4'b0010, 1'b0);
    chk("fixed_release", 32'(bus.g), 32'h0);
    cycle(1'b1, 4'b0010, 1'b0);
    chk("fixed_next_g", 32'(bus.g), 32'h2);
    chk("fixed_next_gcode", 32'(bus.gcode), 32'h2);

    cycle(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 5 * (MAX_HOLD + 1); i++) cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b1, 4'b0000, 1'b1);

    for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);

    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0010, 1'b1);
    chk("pre_rst_g", 32'(bus.g), 32'h2);
    cycle(1'b0, 4'b1111, 1'b1);
    chk("mid_rst_g", 32'(bus.g), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    cycle(1'b1, 4'b1111, 1'b1);
    chk("post_rst_g", 32'(bus.g), 32'h8);

    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1001, 1'b0);
    chk("ignore_g", 32'(bus.g), 32'h1);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    chk("pulse_g", 32'(bus.g), 32'h1);
    cycle(1'b1, 4'b0000, 1'b0);
    chk("pulse_end", 32'(bus.g), 32'h0);

    rv = 4'b0000; md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) md = ~md;
      rn = ($urandom_range(0, 99) != 0);
      cycle(rn, rv, md);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
